// File: rtl/game_fsm.sv
// Tic-tac-toe game controller: arbitrates player and AI turns, holds the 3x3
// board, counts moves and detects win/draw; restarts on player confirm after game over.
module game_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  p_tick,
    input  logic        p_confirm,
    input  logic [3:0]  ai_tick,
    input  logic        ai_ack,
    output logic        ai_confirm,
    output logic [17:0] cell_position,
    output logic [1:0]  winner,
    output logic        player_turn,
    output logic [3:0]  move_cnt
);

    typedef enum logic [2:0] {
        P_WAIT    = 3'd0,
        P_CHECK   = 3'd1,
        AI_WAIT   = 3'd2,
        AI_CHECK  = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_AI     = 2'b10;
    localparam logic [1:0] WIN_NONE    = 2'b00;
    localparam logic [1:0] WIN_DRAW    = 2'b11;
    localparam logic [3:0] MAX_MOVES   = 4'd9;

    state_t      state, state_n;
    logic [17:0] cells_n;
    logic [1:0]  winner_n;
    logic [3:0]  cnt_n;
    logic        p_confirm_q;
    logic        p_conf_rise;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] v;
        v = CELL_EMPTY;
        for (int unsigned i = 0; i < 9; i++) begin
            if (idx == 4'(i)) v = b[2*i +: 2];
        end
        return v;
    endfunction

    function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] idx,
                                             input logic [1:0] who);
        logic [17:0] r;
        r = b;
        for (int unsigned i = 0; i < 9; i++) begin
            if (idx == 4'(i)) r[2*i +: 2] = who;
        end
        return r;
    endfunction

    function automatic logic owns3(input logic [17:0] b, input logic [3:0] a,
                                   input logic [3:0] c, input logic [3:0] d,
                                   input logic [1:0] who);
        return (cell_at(b, a) == who) && (cell_at(b, c) == who) && (cell_at(b, d) == who);
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] who);
        return owns3(b, 4'd0, 4'd1, 4'd2, who) || owns3(b, 4'd3, 4'd4, 4'd5, who) ||
               owns3(b, 4'd6, 4'd7, 4'd8, who) || owns3(b, 4'd0, 4'd3, 4'd6, who) ||
               owns3(b, 4'd1, 4'd4, 4'd7, who) || owns3(b, 4'd2, 4'd5, 4'd8, who) ||
               owns3(b, 4'd0, 4'd4, 4'd8, who) || owns3(b, 4'd2, 4'd4, 4'd6, who);
    endfunction

    assign p_conf_rise = p_confirm & ~p_confirm_q;
    assign player_turn = (state == P_WAIT);
    assign ai_confirm  = (state == AI_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= P_WAIT;
            cell_position <= '0;
            winner        <= WIN_NONE;
            move_cnt      <= '0;
            p_confirm_q   <= 1'b0;
        end else begin
            state         <= state_n;
            cell_position <= cells_n;
            winner        <= winner_n;
            move_cnt      <= cnt_n;
            p_confirm_q   <= p_confirm;
        end
    end

    always_comb begin
        state_n  = state;
        cells_n  = cell_position;
        winner_n = winner;
        cnt_n    = move_cnt;
        case (state)
            P_WAIT: begin
                if (p_conf_rise && (p_tick <= 4'd8) && (move_cnt != MAX_MOVES) &&
                    (cell_at(cell_position, p_tick) == CELL_EMPTY)) begin
                    cells_n = set_cell(cell_position, p_tick, CELL_PLAYER);
                    cnt_n   = move_cnt + 4'd1;
                    state_n = P_CHECK;
                end
            end
            P_CHECK: begin
                // A win on the ninth move outranks the draw
                if (has_line(cell_position, CELL_PLAYER)) begin
                    winner_n = CELL_PLAYER;
                    state_n  = GAME_OVER;
                end else if (move_cnt == MAX_MOVES) begin
                    winner_n = WIN_DRAW;
                    state_n  = GAME_OVER;
                end else begin
                    state_n = AI_WAIT;
                end
            end
            AI_WAIT: begin
                if (ai_ack && (ai_tick <= 4'd8) && (move_cnt != MAX_MOVES) &&
                    (cell_at(cell_position, ai_tick) == CELL_EMPTY)) begin
                    cells_n = set_cell(cell_position, ai_tick, CELL_AI);
                    cnt_n   = move_cnt + 4'd1;
                    state_n = AI_CHECK;
                end
            end
            AI_CHECK: begin
                if (has_line(cell_position, CELL_AI)) begin
                    winner_n = CELL_AI;
                    state_n  = GAME_OVER;
                end else if (move_cnt == MAX_MOVES) begin
                    winner_n = WIN_DRAW;
                    state_n  = GAME_OVER;
                end else begin
                    state_n = P_WAIT;
                end
            end
            GAME_OVER: begin
                if (p_conf_rise) begin
                    cells_n  = '0;
                    winner_n = WIN_NONE;
                    cnt_n    = '0;
                    state_n  = P_WAIT;
                end
            end
            default: state_n = P_WAIT;
        endcase
    end

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: scripted games with hand-computed board, winner and count.
module tb_game_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  p_tick = '0;
    logic        p_confirm = 1'b0;
    logic [3:0]  ai_tick = '0;
    logic        ai_ack = 1'b0;
    logic        ai_confirm;
    logic [17:0] cell_position;
    logic [1:0]  winner;
    logic        player_turn;
    logic [3:0]  move_cnt;

    int checks = 0;
    int errors = 0;

    game_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .p_tick       (p_tick),
        .p_confirm    (p_confirm),
        .ai_tick      (ai_tick),
        .ai_ack       (ai_ack),
        .ai_confirm   (ai_confirm),
        .cell_position(cell_position),
        .winner       (winner),
        .player_turn  (player_turn),
        .move_cnt     (move_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [17:0] cells,
                             input logic [1:0] win, input logic [3:0] cnt,
                             input logic pt, input logic aic);
        check({tag, ".state"}, 32'(dut.state), 32'(st));
        check({tag, ".cells"}, 32'(cell_position), 32'(cells));
        check({tag, ".winner"}, 32'(winner), 32'(win));
        check({tag, ".move_cnt"}, 32'(move_cnt), 32'(cnt));
        check({tag, ".player_turn"}, 32'(player_turn), 32'(pt));
        check({tag, ".ai_confirm"}, 32'(ai_confirm), 32'(aic));
    endtask

    // One-cycle confirm pulse; returns after the check state has resolved
    task automatic pmove(input logic [3:0] idx);
        @(negedge clk); p_tick = idx; p_confirm = 1'b1;
        @(negedge clk); p_confirm = 1'b0;
        @(negedge clk);
    endtask

    task automatic amove(input logic [3:0] idx);
        @(negedge clk); ai_tick = idx; ai_ack = 1'b1;
        @(negedge clk); ai_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk); p_tick = 4'd3; p_confirm = 1'b1;
        @(negedge clk);
        @(negedge clk); p_confirm = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all("reset_held", 3'd0, '0, 2'b00, 4'd0, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_all("reset_rel", 3'd0, '0, 2'b00, 4'd0, 1'b1, 1'b0);

        // Player row 0-1-2 win
        pmove(4'd0);
        check_all("p0", 3'd2, 18'b01, 2'b00, 4'd1, 1'b0, 1'b1);
        amove(4'd4);
        check_all("a4", 3'd0, 18'b00_00_00_00_10_00_00_00_01, 2'b00, 4'd2, 1'b1, 1'b0);
        pmove(4'd0);
        check_all("p_occupied", 3'd0, 18'b00_00_00_00_10_00_00_00_01, 2'b00, 4'd2, 1'b1, 1'b0);
        pmove(4'd9);
        check_all("p_tick9", 3'd0, 18'b00_00_00_00_10_00_00_00_01, 2'b00, 4'd2, 1'b1, 1'b0);
        pmove(4'd1);
        amove(4'd4);
        check_all("a_occupied", 3'd2, 18'b00_00_00_00_10_00_00_01_01, 2'b00, 4'd3, 1'b0, 1'b1);
        amove(4'd12);
        check_all("a_tick12", 3'd2, 18'b00_00_00_00_10_00_00_01_01, 2'b00, 4'd3, 1'b0, 1'b1);
        amove(4'd8);
        pmove(4'd2);
        check_all("p_win", 3'd4, 18'b10_00_00_00_10_00_01_01_01, 2'b01, 4'd5, 1'b0, 1'b0);
        amove(4'd3);
        check_all("over_hold", 3'd4, 18'b10_00_00_00_10_00_01_01_01, 2'b01, 4'd5, 1'b0, 1'b0);

        restart();
        check_all("restart", 3'd0, '0, 2'b00, 4'd0, 1'b1, 1'b0);

        // Draw: P0 A1 P2 A4 P3 A5 P7 A6 P8
        pmove(4'd0); amove(4'd1); pmove(4'd2); amove(4'd4);
        pmove(4'd3); amove(4'd5); pmove(4'd7); amove(4'd6);
        check_all("pre_draw", 3'd0, 18'b00_01_10_10_10_01_01_10_01, 2'b00, 4'd8, 1'b1, 1'b0);
        pmove(4'd8);
        check_all("draw", 3'd4, 18'b01_01_10_10_10_01_01_10_01, 2'b11, 4'd9, 1'b0, 1'b0);

        restart();
        check_all("restart2", 3'd0, '0, 2'b00, 4'd0, 1'b1, 1'b0);

        // AI column 1-4-7
        pmove(4'd0); amove(4'd4); pmove(4'd2); amove(4'd1); pmove(4'd5); amove(4'd7);
        check_all("ai_win", 3'd4, 18'b00_10_00_01_10_00_01_10_01, 2'b10, 4'd6, 1'b0, 1'b0);

        restart();
        // Async reset mid-game
        pmove(4'd6);
        check_all("pre_abort", 3'd2, 18'b01_00_00_00_00_00_00, 2'b00, 4'd1, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_all("abort", 3'd0, '0, 2'b00, 4'd0, 1'b1, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
Name: game_fsm

Overview:
Top-level tic-tac-toe game controller. It arbitrates turns between a human player, who moves through a position select and confirm, and an external AI engine, which moves through a request/acknowledge handshake. It holds the 3x3 board, counts moves, detects a win or a draw, and restarts on player confirm after game over. It sits between the input debouncers/AI core and the display/LED logic.

Parameters:
none (board fixed at 9 cells, 2 bits per cell)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
p_tick  input  4  player-selected cell index 0..8
p_confirm  input  1  player confirm/restart; acted on at its rising edge only
ai_tick  input  4  AI-selected cell index 0..8, valid with ai_ack
ai_ack  input  1  AI move valid strobe, level-sampled while ai_confirm=1
ai_confirm  output  1  request to AI engine: high while waiting for an AI move
cell_position  output  18  board; cell i at bits [2i+1:2i]; 00 empty, 01 player, 10 AI
winner  output  2  00 none/in progress, 01 player, 10 AI, 11 draw
player_turn  output  1  1 while waiting for a player move
move_cnt  output  4  number of accepted moves, 0..9

Behaviour:
- State register is named `state`. It has 5 states, encoded: P_WAIT=0, P_CHECK=1, AI_WAIT=2, AI_CHECK=3, GAME_OVER=4.
- Reset (rst=0, async): state=P_WAIT, cell_position=0, winner=00, move_cnt=0, player_turn=1, ai_confirm=0, p_confirm edge register=0. The player always moves first.
- p_confirm edge detect: p_conf_rise = p_confirm & ~p_confirm_q, where p_confirm_q is registered every clk. A confirm held for N cycles counts as one event.
- P_WAIT (player_turn=1):
  - On p_conf_rise with p_tick<=8 and the target cell empty: write 01 to cell p_tick, move_cnt+1, go to P_CHECK.
  - If p_tick>8 or the cell is occupied: ignore the move and stay in P_WAIT.
  - ai_ack is ignored in this state.
- P_CHECK (1 cycle, player_turn=0), using the updated board:
  - Player owns any of the 8 lines (rows 012/345/678, columns 036/147/258, diagonals 048/246): winner=01, go to GAME_OVER.
  - Else if move_cnt==9: winner=11, go to GAME_OVER.
  - Else go to AI_WAIT.
- AI_WAIT (ai_confirm=1, player_turn=0):
  - On ai_ack=1 at a clk edge with ai_tick<=8 and the cell empty: write 10 to cell ai_tick, move_cnt+1, go to AI_CHECK.
  - ai_confirm deasserts in the next cycle.
  - An invalid ai_tick is ignored: stay in AI_WAIT with ai_confirm held high.
  - p_confirm edges are ignored in this state.
- AI_CHECK (1 cycle): same check as P_CHECK. An AI line gives winner=10. Else move_cnt==9 gives winner=11. Else go to P_WAIT.
- Win takes priority over draw when both occur on the 9th move.
- GAME_OVER (player_turn=0, ai_confirm=0):
  - Board, winner and move_cnt hold their values.
  - On p_conf_rise: clear the board, winner=00, move_cnt=0, go to P_WAIT.
  - The held-high remainder of that confirm must not place a move (edge detect guarantees this).
  - ai_ack is ignored.
- All outputs are registered (or decoded from `state`). There are no combinational paths from inputs to outputs.
- move_cnt never exceeds 9 and does not wrap.
- Reset asserted mid-game aborts immediately to the reset values.

Test Plan:
- Reset, then release -> state=0, player_turn=1, cell_position=0, winner=00, move_cnt=0, ai_confirm=0.
- Player 0, AI 4, player 1, AI 8, player 2 -> after P_CHECK: winner=01, move_cnt=5, cell_position=18'b10_00_00_00_10_00_01_01_01, state=4, ai_confirm=0.
- In GAME_OVER, hold p_confirm high for 2 cycles -> cell_position=0, winner=00, move_cnt=0, player_turn=1, state=0, and no cell gets written.
- Player confirms an occupied cell (0 after a move at 0), or p_tick=9 -> board and move_cnt unchanged, remains in P_WAIT; the AI writing an occupied cell -> ai_confirm stays 1.
- Full board with no line (P0, A1, P2, A4, P3, A5, P7, A6, P8) -> winner=11, move_cnt=9.
- AI completes column 1-4-7 (P0, A4, P2, A1, P5, A7) -> winner=10, move_cnt=6.
